// File: rtl/values_to_bit_stream_if.sv
// rtl/values_to_bit_stream_if.sv - vector-in / bit-position-out stream bundle
interface values_to_bit_stream_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  localparam int IDX_W = $clog2(DATA_W);

  logic                      InValid;
  logic                      InReady;
  logic [LANES*DATA_W-1:0]   InValues;
  logic                      OutValid;
  logic                      OutReady;
  logic [LANES*IDX_W-1:0]    OutBitPlace;
  logic [LANES-1:0]          OutLaneValid;
  logic                      OutLast;

  modport master (
    output InValid, InValues, OutReady,
    input  InReady, OutValid, OutBitPlace, OutLaneValid, OutLast
  );

  modport slave (
    input  InValid, InValues, OutReady,
    output InReady, OutValid, OutBitPlace, OutLaneValid, OutLast
  );
endinterface

// File: rtl/values_to_bit_stream.sv
// rtl/values_to_bit_stream.sv - multi-lane set-bit position emitter
// Each accepted vector yields max(1, max lane popcount) beats; the final beat carries OutLast.
module values_to_bit_stream #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  values_to_bit_stream_if.slave  bus
);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e                             state_q, state_d;
  logic [LANES-1:0][DATA_W-1:0]       rem_q, rem_d;
  logic [LANES-1:0][IDX_W-1:0]        place;
  logic [LANES-1:0]                   lane_valid;
  logic [LANES-1:0]                   lane_single;
  logic                               out_valid;
  logic                               out_last;
  logic                               in_ready;
  logic                               accept;
  logic                               beat;

  // Last write wins, so the scan direction picks the lowest or highest set bit.
  function automatic logic [IDX_W-1:0] pick_bit(input logic [DATA_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int b = 0; b < DATA_W; b++) begin
      if (MSB_FIRST) begin
        if (v[b]) idx = IDX_W'(b);
      end else begin
        if (v[DATA_W-1-b]) idx = IDX_W'(DATA_W-1-b);
      end
    end
    return idx;
  endfunction

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    accept  = bus.InValid && in_ready;
    beat    = out_valid && bus.OutReady;
    state_d = state_q;
    rem_d   = rem_q;
    if (beat) begin
      for (int i = 0; i < LANES; i++) begin
        rem_d[i] = rem_q[i] & ~(DATA_W'(lane_valid[i]) << place[i]);
      end
    end
    // A new vector overrides the final clear, giving back-to-back groups.
    if (accept) begin
      rem_d   = bus.InValues;
      state_d = EMIT;
    end else if (beat && out_last) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    out_valid = (state_q == EMIT);
    for (int i = 0; i < LANES; i++) begin
      lane_valid[i]  = out_valid && (|rem_q[i]);
      lane_single[i] = ((rem_q[i] & (rem_q[i] - DATA_W'(1))) == '0);
      place[i]       = lane_valid[i] ? pick_bit(rem_q[i]) : '0;
    end
    out_last = out_valid && (&lane_single);
    in_ready = !out_valid || (out_last && bus.OutReady);
  end

  assign bus.InReady      = in_ready;
  assign bus.OutValid     = out_valid;
  assign bus.OutBitPlace  = place;
  assign bus.OutLaneValid = lane_valid;
  assign bus.OutLast      = out_last;

endmodule

// File: tb/tb_values_to_bit_stream.sv
// tb/tb_values_to_bit_stream.sv - randomized model-checked bench for values_to_bit_stream
module tb_values_to_bit_stream;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  values_to_bit_stream_if #(.DATA_W(8), .LANES(4)) a();
  values_to_bit_stream_if #(.DATA_W(8), .LANES(1)) b();

  values_to_bit_stream #(.DATA_W(8), .LANES(4), .MSB_FIRST(1'b0)) dut_a (
    .CLK(clk), .RSTN(rstn), .bus(a.slave));
  values_to_bit_stream #(.DATA_W(8), .LANES(1), .MSB_FIRST(1'b1)) dut_b (
    .CLK(clk), .RSTN(rstn), .bus(b.slave));

  typedef struct packed {
    logic [11:0] place;
    logic [3:0]  lv;
    logic        last;
  } beat_t;

  beat_t exp_a[$];
  beat_t exp_b[$];
  beat_t ea, eb;
  int checks = 0, errors = 0;
  int cyc = 0, beats_a = 0, beats_b = 0, base = 0;
  int first_cyc = -1, last_cyc = -1;
  bit rand_rdy = 1'b0;

  logic [11:0] hp_a; logic [3:0] hl_a; logic hx_a; bit hold_a = 1'b0;
  logic [2:0]  hp_b; logic hl_b; logic hx_b; bit hold_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: list each lane's set-bit positions in scan order, then read them out column-wise.
  task automatic model_push(input logic [31:0] v, input int lanes, input bit msb, input bit to_b);
    int    pos[4][$];
    int    n;
    beat_t e;
    n = 1;
    for (int l = 0; l < lanes; l++) begin
      for (int bt = 0; bt < 8; bt++) begin
        if (v[l*8+bt]) begin
          if (msb) pos[l].push_front(bt);
          else     pos[l].push_back(bt);
        end
      end
      if (pos[l].size() > n) n = pos[l].size();
    end
    for (int k = 0; k < n; k++) begin
      e = '0;
      for (int l = 0; l < lanes; l++) begin
        if (k < pos[l].size()) begin
          e.lv[l] = 1'b1;
          e.place[l*3 +: 3] = 3'(pos[l][k]);
        end
      end
      e.last = (k == n - 1);
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    a.OutReady = 1'b1;
    b.OutReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      a.OutReady = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      b.OutReady = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      hold_a = 1'b0;
    end else if (!a.OutValid) begin
      hold_a = 1'b0;
      check("a_idle_inready", a.InReady, 1);
      check("a_idle_lanevalid", a.OutLaneValid, 0);
    end else begin
      if (hold_a) begin
        check("a_stall_place", a.OutBitPlace, hp_a);
        check("a_stall_lanevalid", a.OutLaneValid, hl_a);
        check("a_stall_last", a.OutLast, hx_a);
      end
      if (!(a.OutLast && a.OutReady)) check("a_busy_inready", a.InReady, 0);
      if (a.OutReady) begin
        hold_a = 1'b0;
        if (exp_a.size() == 0) check("a_unexpected_beat", 1, 0);
        else begin
          ea = exp_a.pop_front();
          check("a_place", a.OutBitPlace, ea.place);
          check("a_lanevalid", a.OutLaneValid, ea.lv);
          check("a_last", a.OutLast, ea.last);
        end
        beats_a++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end else begin
        hold_a = 1'b1;
        hp_a = a.OutBitPlace; hl_a = a.OutLaneValid; hx_a = a.OutLast;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      hold_b = 1'b0;
    end else if (!b.OutValid) begin
      hold_b = 1'b0;
      check("b_idle_inready", b.InReady, 1);
    end else begin
      if (hold_b) begin
        check("b_stall_place", b.OutBitPlace, hp_b);
        check("b_stall_lanevalid", b.OutLaneValid, hl_b);
        check("b_stall_last", b.OutLast, hx_b);
      end
      if (!(b.OutLast && b.OutReady)) check("b_busy_inready", b.InReady, 0);
      if (b.OutReady) begin
        hold_b = 1'b0;
        if (exp_b.size() == 0) check("b_unexpected_beat", 1, 0);
        else begin
          eb = exp_b.pop_front();
          check("b_place", b.OutBitPlace, eb.place[2:0]);
          check("b_lanevalid", b.OutLaneValid, eb.lv[0]);
          check("b_last", b.OutLast, eb.last);
        end
        beats_b++;
      end else begin
        hold_b = 1'b1;
        hp_b = b.OutBitPlace; hl_b = b.OutLaneValid; hx_b = b.OutLast;
      end
    end
  end

  task automatic send_a(input logic [31:0] v);
    int t = 0;
    a.InValid = 1'b1; a.InValues = v;
    @(negedge clk);
    while (!a.InReady && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("a_accept_timeout", 0, 1);
    else model_push(v, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    a.InValid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    int t = 0;
    b.InValid = 1'b1; b.InValues = v;
    @(negedge clk);
    while (!b.InReady && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("b_accept_timeout", 0, 1);
    else model_push({24'h0, v}, 1, 1'b1, 1'b1);
    @(posedge clk); #1;
    b.InValid = 1'b0;
  endtask

  task automatic drain_a();
    int t = 0;
    while ((exp_a.size() != 0 || a.OutValid) && t < 500) begin @(posedge clk); #1; t++; end
    check("a_drain_in_time", t < 500, 1);
  endtask

  task automatic drain_b();
    int t = 0;
    while ((exp_b.size() != 0 || b.OutValid) && t < 500) begin @(posedge clk); #1; t++; end
    check("b_drain_in_time", t < 500, 1);
  endtask

  function automatic logic [7:0] rnd_lane();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'(1 << $urandom_range(0, 7));
      2:       return 8'($urandom & $urandom);
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    a.InValid = 1'b0; a.InValues = '0;
    b.InValid = 1'b0; b.InValues = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_outvalid", a.OutValid, 0);
    check("rst_inready", a.InReady, 1);
    check("rst_last", a.OutLast, 0);
    check("rst_lanevalid", a.OutLaneValid, 0);
    check("rst_place", a.OutBitPlace, 0);
    a.InValid = 1'b1; a.InValues = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("rst_ignores_input", a.OutValid, 0);
    a.InValid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    base = beats_a; send_a(32'h03); drain_a();
    check("a_beats_03", beats_a - base, 2);
    base = beats_a; send_a(32'hF7); drain_a();
    check("a_beats_F7", beats_a - base, 7);
    base = beats_a; send_a(32'h0080_05FF); drain_a();
    check("a_beats_mixed", beats_a - base, 8);

    base = beats_a; first_cyc = -1;
    send_a(32'h0); send_a(32'h1); drain_a();
    check("a_beats_zero_b2b", beats_a - base, 2);
    check("a_zero_b2b_contig", last_cyc - first_cyc, 1);

    rand_rdy = 1'b1;
    base = beats_a; send_a(32'hF7); drain_a();
    check("a_beats_F7_bp", beats_a - base, 7);

    for (int i = 0; i < 40; i++) begin
      rand_rdy = ($urandom_range(0, 1) == 1);
      send_a({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()});
    end
    drain_a();

    rand_rdy = 1'b0;
    base = beats_a; first_cyc = -1;
    for (int i = 0; i < 6; i++) send_a({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()});
    drain_a();
    check("a_burst_contig", last_cyc - first_cyc, beats_a - base - 1);

    base = beats_a;
    send_a(32'hF7);
    begin
      int t = 0;
      while (beats_a != base + 2 && t < 50) begin @(posedge clk); #1; t++; end
      check("a_reach_beat3", beats_a - base, 2);
    end
    rstn = 1'b0; #1;
    check("a_midrst_outvalid", a.OutValid, 0);
    check("a_midrst_inready", a.InReady, 1);
    exp_a.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    check("a_postrst_idle", a.OutValid, 0);
    base = beats_a; send_a(32'h03); drain_a();
    check("a_postrst_beats", beats_a - base, 2);

    base = beats_b; send_b(8'hF7); drain_b();
    check("b_beats_F7", beats_b - base, 7);
    base = beats_b; send_b(8'h00); drain_b();
    check("b_beats_zero", beats_b - base, 1);
    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) send_b(rnd_lane());
    drain_b();
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/values_to_bit_stream.md
# values_to_bit_stream

Parametrised multi-lane bit-sparsity converter. It accepts a vector of `LANES` unsigned `DATA_W`-bit values and emits the position of every set bit, one position per lane per beat, skipping zero bits. The beat count per vector is the maximum popcount across lanes. It sits between the activation/weight buffers and the bit-serial PE array. It replaces the single-lane, fixed-8-bit, handshake-less converter with valid/ready flow control, back-to-back vector acceptance, a selectable scan order and a group-end marker.

## Interface
Parameters:
- `DATA_W`, default 8: bits per value; must be at least 2.
- `LANES`, default 4: number of values per vector; must be at least 1.
- `MSB_FIRST`, default 0: 0 emits positions in ascending order (bit 0 first); 1 emits them in descending order.
- `IDX_W`, default `$clog2(DATA_W)`: width of one bit-position index; derived, not overridden.

Ports:
- `CLK`, input, 1: the single clock; all state is on the rising edge.
- `RSTN`, input, 1: reset, asynchronous and active-low.
- `InValid`, input, 1: the input vector is valid.
- `InReady`, output, 1: the block can accept a vector this cycle.
- `InValues`, input, `LANES*DATA_W`: packed vector; lane `i` is bits `[i*DATA_W +: DATA_W]`.
- `OutValid`, output, 1: an output beat is presented.
- `OutReady`, input, 1: the downstream block accepts the beat.
- `OutBitPlace`, output, `LANES*IDX_W`: bit position per lane, packed the same way as `InValues`.
- `OutLaneValid`, output, `LANES`: the lane carries a real position this beat.
- `OutLast`, output, 1: this is the final beat of the current vector.

## Operation
- State machine with two states.
  - `IDLE`: no vector is held.
  - `EMIT`: a per-lane remaining-bit mask `Rem[i]` (`DATA_W` bits) is held.
- Accept: an input transfer happens when `InValid && InReady`. `Rem` loads `InValues` and the state goes to `EMIT`.
- `InReady = (state==IDLE) || (state==EMIT && OutLast && OutReady)`.
  - This allows back-to-back vectors with no bubble.
  - `InReady` depends combinationally on `OutReady`. The block has no other combinational input-to-output path.
- In `EMIT`, `OutValid` = 1.
  - Per lane, `OutLaneValid[i] = |Rem[i]`.
  - `OutBitPlace[i]` is the index of the lowest set bit of `Rem[i]` (`MSB_FIRST`=0) or the highest set bit (`MSB_FIRST`=1).
  - `OutBitPlace[i]` is 0 when the lane is invalid.
- `OutLast` = 1 when every lane has at most one set bit remaining.
- Beat transfer (`OutValid && OutReady`): the emitted bit in each valid lane is cleared from `Rem`.
  - If `OutLast` and a new vector is accepted in the same cycle, `Rem` loads the new vector and the state stays `EMIT`.
  - If `OutLast` and no new vector is accepted, the state goes to `IDLE`.
- An all-zero vector still produces exactly one beat: `OutLaneValid` = 0, `OutLast` = 1, all `OutBitPlace` = 0. Downstream always sees one group end per accepted vector.
- Stall: while `OutValid && !OutReady`, all outputs and `Rem` hold stable, and no input is accepted.
- Number of beats per vector = max(1, max over i of popcount(`InValues` lane i)). The range is 1 to `DATA_W`.

## Timing
- Reset (`RSTN` low, asynchronous): the state is `IDLE`, `Rem` is 0, `OutValid` = 0, `OutLaneValid` = 0, `OutBitPlace` = 0, `OutLast` = 0, `InReady` = 1.
  - Inputs are ignored while `RSTN` is low.
  - Deassertion is synchronised externally.
- Latency: a vector accepted at edge N gives its first beat on `OutValid` after edge N (one cycle).
- Outputs are registered-state decodes (from `Rem` and the state). They are glitch-free relative to `CLK`.
- Reset mid-vector: the in-flight vector is discarded with no `OutLast` beat. The first cycle after reset release behaves as `IDLE`.
- Throughput: one beat per cycle with `OutReady` held high. Successive vectors are contiguous (the `OutLast` beat of vector k is immediately followed by the first beat of vector k+1).

## Test plan
- Single lane (`LANES`=1, `DATA_W`=8, `MSB_FIRST`=0), input 0x03, `OutReady`=1 -> two beats.
  - Beat 1: `OutBitPlace` = 0, `OutLast` = 0.
  - Beat 2: `OutBitPlace` = 1, `OutLast` = 1.
  - Then `IDLE` with `InReady` = 1.
- Same configuration, input 0xF7 -> seven beats with positions 0, 1, 2, 4, 5, 6, 7. `OutLast` is set only on position 7. Repeat with `MSB_FIRST`=1 -> 7, 6, 5, 4, 2, 1, 0.
- `LANES`=4, vector {0x00, 0x80, 0x05, 0xFF} (lane 3 down to lane 0) -> eight beats.
  - Lane 0 emits 0..7 on beats 1-8.
  - Lane 1 emits 0, 2 on beats 1-2, then is invalid.
  - Lane 2 emits 7 on beat 1, then is invalid.
  - Lane 3 is never valid.
  - `OutLast` is set only on beat 8.
- All-zero vector -> exactly one beat with `OutLaneValid` = 0000 and `OutLast` = 1. Then back-to-back with 0x01 on lane 0 -> the next beat immediately follows with position 0 and `OutLast` = 1, with no idle cycle.
- Backpressure: random `OutReady` during 0xF7 -> the position sequence is unchanged, outputs hold during stalls, and `InReady` stays 0 until the `OutLast` transfer.
- Assert `RSTN` low during beat 3 of 0xF7 -> on the same cycle `OutValid` = 0 and `InReady` = 1. After release, a new 0x03 produces positions 0, 1 with no stale bits.
